bch_sigma_arbiter: RTL

Round-robin scheduler that shares one serial Berlekamp–Massey sigma solver (start/ready/done/ack_done handshake) between N syndrome requesters. Each decoder channel computes syndromes and raises a request. The arbiter latches the winning channel's syndromes, starts the solver, and tags the job with the channel id. It then returns sigma and err_count through a one-entry result buffer with a valid/ack handshake. It sits between the per-channel syndrome stages and the shared Chien-search/error-locate stage.

---
 rtl/bch_sigma_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bch_sigma_arbiter.sv
// Round-robin front end that time-shares one serial Berlekamp-Massey sigma solver
// between N syndrome requesters and returns tagged results through a one-entry buffer.
module bch_sigma_arbiter #(
  parameter int N   = 4,
  parameter int SYN = 16,
  parameter int SIG = 12,
  parameter int ERR = 3,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic [N*SYN-1:0] syndromes_in,
  output logic [N-1:0]     gnt,
  output logic             solver_start,
  output logic [SYN-1:0]   solver_syndromes,
  input  logic             solver_ready,
  input  logic             solver_done,
  input  logic [SIG-1:0]   solver_sigma,
  input  logic [ERR-1:0]   solver_err_count,
  output logic             solver_ack_done,
  output logic             res_valid,
  output logic [IDW-1:0]   res_id,
  output logic [SIG-1:0]   res_sigma,
  output logic [ERR-1:0]   res_err_count,
  input  logic             res_ack
);

  // state  | meaning
  // S_IDLE | no job in flight; grant next requester or drain an orphan done
  // S_RUN  | solver busy with job_id; capture its result when the buffer is free
  // S_HOLD | solver finished but result buffer full; result left pending in solver
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] job_id;
  logic [IDW-1:0] win;
  logic           win_found;
  logic           grant_fire;
  logic           capture;

  // Rotating-priority search: first set request at or after ptr, wrapping modulo N.
  always_comb begin
    int idx;
    idx       = 0;
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win       = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_fire      = 1'b0;
    capture         = 1'b0;
    solver_ack_done = 1'b0;
    case (state)
      S_IDLE: begin
        // A done seen here belongs to a job from before reset; drop it.
        if (solver_done) begin
          solver_ack_done = 1'b1;
        end else if (win_found && solver_ready) begin
          grant_fire = 1'b1;
          state_nxt  = S_RUN;
        end
      end
      S_RUN, S_HOLD: begin
        if (solver_done) begin
          if (!res_valid || res_ack) begin
            capture         = 1'b1;
            solver_ack_done = 1'b1;
            state_nxt       = S_IDLE;
          end else begin
            state_nxt = S_HOLD;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr              <= '0;
      gnt              <= '0;
      solver_start     <= 1'b0;
      solver_syndromes <= '0;
      job_id           <= '0;
    end else begin
      gnt          <= '0;
      solver_start <= 1'b0;
      if (grant_fire) begin
        gnt[win]         <= 1'b1;
        solver_start     <= 1'b1;
        solver_syndromes <= syndromes_in[int'(win)*SYN +: SYN];
        job_id           <= win;
        ptr              <= (win == IDW'(N-1)) ? '0 : win + 1'b1;
      end
    end
  end

  // A capture on the same edge as res_ack reloads the buffer instead of clearing it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid     <= 1'b0;
      res_id        <= '0;
      res_sigma     <= '0;
      res_err_count <= '0;
    end else if (capture) begin
      res_valid     <= 1'b1;
      res_id        <= job_id;
      res_sigma     <= solver_sigma;
      res_err_count <= solver_err_count;
    end else if (res_ack && res_valid) begin
      res_valid <= 1'b0;
    end
  end

endmodule
